calculador_crc32: RTL and testbench

CALCULADOR_CRC32 -- requirements
Module: calculador_crc32

---
 rtl/crc_pkg.sv | 31 +++
 rtl/crc32_byte.sv | 27 ++
 rtl/calculador_crc32.sv | 130 +++++++++++++
 tb/tb_calculador_crc32.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the CRC-32/IEEE frame checker.
// The reflected polynomial is used because bytes are absorbed LSB first.
package crc_pkg;

    // Reflected CRC-32/IEEE parameters
    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

    // Frame-controller states, kept as plain constants so that older tools
    // and hand-written waveform decoders see a fixed two-bit encoding
    typedef logic [1:0] estado_t;

    localparam estado_t ST_IDLE     = 2'd0;
    localparam estado_t ST_RECEBE   = 2'd1;
    localparam estado_t ST_FINALIZA = 2'd2;
    localparam estado_t ST_PRONTO   = 2'd3;

    // One shift step of the reflected CRC register: shift towards the LSB
    // and fold the polynomial back in when a one falls out
    function automatic logic [31:0] crc_bit_step(input logic [31:0] c);
        logic [31:0] shifted;
        shifted = {1'b0, c[31:1]};
        if (c[0]) begin
            return shifted ^ CRC_POLY;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Purely combinational absorption of one byte into a running reflected
// CRC-32. All eight bit steps are unrolled so a byte is consumed per cycle.
module crc32_byte
    import crc_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] next_crc
);

    // The byte is XORed into the low end first because bits enter LSB first
    function automatic logic [31:0] absorb_byte(input logic [31:0] c_in,
                                                input logic [7:0]  d_in);
        logic [31:0] acc;
        acc = c_in ^ {24'h000000, d_in};
        for (int i = 0; i < 8; i++) begin
            acc = crc_bit_step(acc);
        end
        return acc;
    endfunction

    // Unrolled eight-step update
    always_comb begin
        next_crc = absorb_byte(crc, data);
    end

endmodule

// File: rtl/calculador_crc32.sv
// Frame CRC-32 checker. A START pulse captures the byte count and the
// expected CRC; payload bytes arrive over a valid/ready handshake; once the
// last byte is absorbed the final CRC and the mismatch flag are registered
// and DONE is raised until the next frame is accepted.
module calculador_crc32
    import crc_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic [31:0]      EXPECTED,
    input  logic [7:0]       DATA_IN,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    output logic [31:0]      CRC_OUT,
    output logic             TESTE_ERRO,
    output logic             DONE,
    output logic             BUSY
);

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_UM   = {{(LEN_W-1){1'b0}}, 1'b1};

    estado_t          estado_q,    estado_d;
    logic [31:0]      crc_q,       crc_d;
    logic [LEN_W-1:0] cnt_q,       cnt_d;
    logic [31:0]      esperado_q,  esperado_d;
    logic [31:0]      crc_out_q,   crc_out_d;
    logic             erro_q,      erro_d;
    logic             done_q,      done_d;

    logic [31:0]      crc_byte_s;
    logic [31:0]      crc_final_s;

    crc32_byte u_crc32_byte (
        .crc      (crc_q),
        .data     (DATA_IN),
        .next_crc (crc_byte_s)
    );

    assign crc_final_s = crc_q ^ CRC_XOROUT;

    // Next-state and datapath decisions for the frame controller
    always_comb begin
        estado_d   = estado_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        esperado_d = esperado_q;
        crc_out_d  = crc_out_q;
        erro_d     = erro_q;
        // DONE follows the PRONTO state one cycle late, so it stays high for
        // the cycle after a new START and appears two cycles after the
        // final transfer
        done_d     = (estado_q == ST_PRONTO);

        case (estado_q)
            ST_IDLE, ST_PRONTO: begin
                if (START) begin
                    crc_d      = CRC_INIT;
                    cnt_d      = LEN;
                    esperado_d = EXPECTED;
                    if (LEN == CNT_ZERO) begin
                        estado_d = ST_FINALIZA;
                    end else begin
                        estado_d = ST_RECEBE;
                    end
                end else begin
                    estado_d = estado_q;
                end
            end

            ST_RECEBE: begin
                // START is deliberately not examined here
                if (DATA_VALID) begin
                    crc_d = crc_byte_s;
                    cnt_d = cnt_q - CNT_UM;
                    if (cnt_q == CNT_UM) begin
                        estado_d = ST_FINALIZA;
                    end else begin
                        estado_d = ST_RECEBE;
                    end
                end else begin
                    estado_d = ST_RECEBE;
                end
            end

            ST_FINALIZA: begin
                crc_out_d = crc_final_s;
                erro_d    = (crc_final_s != esperado_q);
                estado_d  = ST_PRONTO;
            end

            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado_q   <= ST_IDLE;
            crc_q      <= CRC_INIT;
            cnt_q      <= CNT_ZERO;
            esperado_q <= 32'h00000000;
            crc_out_q  <= 32'h00000000;
            erro_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            esperado_q <= esperado_d;
            crc_out_q  <= crc_out_d;
            erro_q     <= erro_d;
            done_q     <= done_d;
        end
    end

    // Handshake and status are decoded from the state register only
    assign DATA_READY = (estado_q == ST_RECEBE);
    assign BUSY       = (estado_q == ST_RECEBE) || (estado_q == ST_FINALIZA);
    assign DONE       = done_q;
    assign CRC_OUT    = crc_out_q;
    assign TESTE_ERRO = erro_q;

endmodule

// File: tb/tb_calculador_crc32.sv
// Self-checking bench for calculador_crc32: a table-driven CRC-32 reference
// model tracks the frame protocol and is compared against every output on
// every falling clock edge, alongside directed checks with literal values.
module tb_calculador_crc32;

    typedef logic [7:0] buf_t [16];

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] LEN;
    logic [31:0] EXPECTED;
    logic [7:0]  DATA_IN;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [31:0] CRC_OUT;
    logic        TESTE_ERRO;
    logic        DONE;
    logic        BUSY;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [31:0] tbl [256];

    calculador_crc32 #(.LEN_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .LEN        (LEN),
        .EXPECTED   (EXPECTED),
        .DATA_IN    (DATA_IN),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .CRC_OUT    (CRC_OUT),
        .TESTE_ERRO (TESTE_ERRO),
        .DONE       (DONE),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Table-driven reference CRC-32/IEEE over the first n bytes of b
    function automatic logic [31:0] crc_ref(input buf_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = tbl[c[7:0] ^ b[i]] ^ (c >> 8);
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic load_str(input string s, output buf_t b);
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) b[i] = s[i];
    endtask

    // ---------------- reference model ----------------
    // phase: 0 waiting, 1 collecting bytes, 2 closing, 3 result shown
    int          m_phase;
    int          m_left;
    int          m_n;
    buf_t        m_buf;
    logic [31:0] m_exp;
    logic [31:0] m_crc;
    logic        m_err;
    logic        m_done;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_phase <= 0;
            m_left  <= 0;
            m_n     <= 0;
            m_exp   <= 32'h0;
            m_crc   <= 32'h0;
            m_err   <= 1'b0;
            m_done  <= 1'b0;
        end else begin
            m_done <= (m_phase == 3);
            if (m_phase == 0 || m_phase == 3) begin
                if (START) begin
                    m_n     <= 0;
                    m_left  <= int'(LEN);
                    m_exp   <= EXPECTED;
                    m_phase <= (LEN == 16'd0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (DATA_VALID) begin
                    m_buf[m_n] <= DATA_IN;
                    m_n        <= m_n + 1;
                    m_left     <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
            end else begin
                m_crc   <= crc_ref(m_buf, m_n);
                m_err   <= (crc_ref(m_buf, m_n) != m_exp);
                m_phase <= 3;
            end
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_busy",  32'(BUSY),       32'(m_phase == 1 || m_phase == 2));
            chk("model_ready", 32'(DATA_READY), 32'(m_phase == 1));
            chk("model_done",  32'(DONE),       32'(m_done));
            chk("model_crc",   CRC_OUT,         m_crc);
            chk("model_erro",  32'(TESTE_ERRO), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Pulse START for one edge; returns on the falling edge after acceptance
    task automatic do_start(input logic [15:0] len, input logic [31:0] exp);
        @(negedge CLK);
        START    = 1'b1;
        LEN      = len;
        EXPECTED = exp;
        @(negedge CLK);
        START    = 1'b0;
    endtask

    task automatic send_buf(input buf_t b, input int n, input bit gaps, input int start_at);
        for (int i = 0; i < n; i++) begin
            DATA_VALID = 1'b1;
            DATA_IN    = b[i];
            if (i == start_at) begin
                START    = 1'b1;
                LEN      = 16'd3;
                EXPECTED = 32'h12345678;
            end
            @(negedge CLK);
            START = 1'b0;
            if (gaps && i != n - 1) begin
                DATA_VALID = 1'b0;
                DATA_IN    = 8'hAA;
                @(negedge CLK);
            end
        end
        DATA_VALID = 1'b0;
    endtask

    // Called on the first falling edge after the last accepted byte
    task automatic fin_check(input string name, input logic [31:0] crc, input logic err);
        chk({name, "_done_k1"}, 32'(DONE), 32'd0);
        @(negedge CLK);
        chk({name, "_done_k2"}, 32'(DONE), 32'd0);
        @(negedge CLK);
        chk({name, "_done_k3"}, 32'(DONE), 32'd1);
        chk({name, "_crc"},     CRC_OUT,   crc);
        chk({name, "_erro"},    32'(TESTE_ERRO), 32'(err));
        chk({name, "_busy"},    32'(BUSY), 32'd0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_crc"},   CRC_OUT,          32'h00000000);
        chk({name, "_erro"},  32'(TESTE_ERRO),  32'd0);
        chk({name, "_done"},  32'(DONE),        32'd0);
        chk({name, "_busy"},  32'(BUSY),        32'd0);
        chk({name, "_ready"}, 32'(DATA_READY),  32'd0);
    endtask

    buf_t b_digits;
    buf_t b_one;

    initial begin
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
            tbl[n] = c;
        end

        // Pin the reference model itself against known check values
        load_str("123456789", b_digits);
        chk("ref_digits", crc_ref(b_digits, 9), 32'hCBF43926);
        b_one    = b_digits;
        b_one[0] = 8'h00;
        chk("ref_byte00", crc_ref(b_one, 1), 32'hD202EF8D);
        b_one[0] = 8'h61;
        chk("ref_byte61", crc_ref(b_one, 1), 32'hE8B7BE43);
        chk("ref_empty",  crc_ref(b_one, 0), 32'h00000000);

        START = 1'b0; DATA_VALID = 1'b0; LEN = 16'd0;
        EXPECTED = 32'h0; DATA_IN = 8'h00; RST = 1'b0;
        #1 RST = 1'b1;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge CLK);
        chk_reset_vals("reset");
        RST = 1'b0;

        // Check string, back to back, matching expectation
        do_start(16'd9, 32'hCBF43926);
        send_buf(b_digits, 9, 1'b0, -1);
        fin_check("t_match", 32'hCBF43926, 1'b0);

        // Same frame from PRONTO with a wrong expectation
        do_start(16'd9, 32'h00000000);
        send_buf(b_digits, 9, 1'b0, -1);
        fin_check("t_mismatch", 32'hCBF43926, 1'b1);

        // Second frame from PRONTO: DONE and old result persist one cycle
        do_start(16'd1, 32'hD202EF8D);
        chk("t_chain_done_hold", 32'(DONE), 32'd1);
        chk("t_chain_crc_hold",  CRC_OUT,   32'hCBF43926);
        b_one[0] = 8'h00;
        DATA_VALID = 1'b1;
        DATA_IN    = 8'h00;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        chk("t_chain_done_drop", 32'(DONE), 32'd0);
        chk("t_chain_crc_keep",  CRC_OUT,   32'hCBF43926);
        chk("t_chain_erro_keep", 32'(TESTE_ERRO), 32'd1);
        // this edge is k2 relative to the single byte
        @(negedge CLK);
        chk("t_byte00_done_k2", 32'(DONE), 32'd0);
        @(negedge CLK);
        chk("t_byte00_done", 32'(DONE), 32'd1);
        chk("t_byte00_crc",  CRC_OUT,   32'hD202EF8D);
        chk("t_byte00_erro", 32'(TESTE_ERRO), 32'd0);

        // Valid bytes while not receiving must be ignored
        DATA_VALID = 1'b1;
        DATA_IN    = 8'h55;
        repeat (3) @(negedge CLK);
        chk("t_idle_ready", 32'(DATA_READY), 32'd0);
        DATA_VALID = 1'b0;
        chk("t_idle_crc_kept", CRC_OUT, 32'hD202EF8D);

        // Single 'a' byte, expectation zero
        b_one[0] = 8'h61;
        do_start(16'd1, 32'h00000000);
        send_buf(b_one, 1, 1'b0, -1);
        fin_check("t_byte61", 32'hE8B7BE43, 1'b1);

        // Empty frame
        do_start(16'd0, 32'h00000000);
        chk("t_len0_busy", 32'(BUSY), 32'd1);
        @(negedge CLK);
        chk("t_len0_done_k2", 32'(DONE), 32'd0);
        @(negedge CLK);
        chk("t_len0_done_k3", 32'(DONE), 32'd1);
        chk("t_len0_crc",     CRC_OUT,   32'h00000000);
        chk("t_len0_erro",    32'(TESTE_ERRO), 32'd0);

        // Gapped stream with a stray START during reception
        do_start(16'd9, 32'hCBF43926);
        send_buf(b_digits, 9, 1'b1, 3);
        fin_check("t_gaps", 32'hCBF43926, 1'b0);

        // Abandon a frame with reset after five bytes, then run a fresh one
        do_start(16'd9, 32'h00000000);
        send_buf(b_digits, 5, 1'b0, -1);
        chk("t_rst_busy_before", 32'(BUSY), 32'd1);
        #2 RST = 1'b1;
        #1 chk_reset_vals("t_rst_async");
        @(negedge CLK);
        chk_reset_vals("t_rst_held");
        RST = 1'b0;
        @(negedge CLK);
        chk_reset_vals("t_rst_after");
        do_start(16'd9, 32'hCBF43926);
        send_buf(b_digits, 9, 1'b0, -1);
        fin_check("t_rst_fresh", 32'hCBF43926, 1'b0);

        repeat (2) @(negedge CLK);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
